// File: rtl/dct_zigzag_quant_pkg.sv
// Shared types and constants for the 4x4 zigzag reorder / power-of-two quantizer.
package dct_zz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    HOLD   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  typedef logic signed [9:0] coef_in_t;
  typedef logic signed [9:0] coef_out_t;

  localparam logic [3:0] ZZ [0:15] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  // Indexed by row+col of the raster position.
  localparam logic [1:0] QSHIFT [0:6] = '{
    2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3
  };

  function automatic logic [1:0] qshift_of(input logic [3:0] idx);
    logic [2:0] sum;
    sum = {1'b0, idx[3:2]} + {1'b0, idx[1:0]};
    return QSHIFT[sum];
  endfunction

endpackage

// File: rtl/dct_zigzag_quant_if.sv
// Coefficient stream into and out of the zigzag/quantizer stage.
interface dct_zigzag_quant_if;
  import dct_zz_pkg::*;

  logic      in_valid;
  coef_in_t  in_data;
  logic      out_valid;
  coef_out_t out_data;
  logic      out_last;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_last
  );

endinterface

// File: rtl/dct_zigzag_quant_round_shift.sv
// Signed arithmetic right shift by 0..3 with round-to-nearest, ties away from zero.
module zz_round_shift
  import dct_zz_pkg::*;
(
  input  coef_in_t   i_x,
  input  logic [1:0] i_s,
  output coef_out_t  o_q
);

  // Magnitude is taken in 11 bits so that -512 survives negation.
  function automatic coef_out_t round_shift(input coef_in_t x, input logic [1:0] s);
    logic signed [10:0] xe;
    logic [10:0]        mag;
    logic [10:0]        half;
    logic [10:0]        rnd;
    logic [10:0]        res;
    xe   = {x[9], x};
    mag  = xe[10] ? 11'(-xe) : 11'(xe);
    half = 11'd0;
    if (s != 2'd0)
      half = 11'd1 << (s - 2'd1);
    rnd  = (mag + half) >> s;
    res  = xe[10] ? 11'(-rnd) : rnd;
    return coef_out_t'(res[9:0]);
  endfunction

  assign o_q = round_shift(i_x, i_s);

endmodule

// File: rtl/dct_zigzag_quant.sv
// Collects a raster 4x4 coefficient block and emits it quantized in zigzag order.
// Define DCT_ZZ_QUANT_EN to enable the quantizer; otherwise the block is a pure reorder.
module dct_zigzag_quant
  import dct_zz_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  dct_zigzag_quant_if.slave  bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_in_cnt;
  logic [3:0] w_in_cnt_nxt;
  logic [3:0] r_out_cnt;
  logic [3:0] w_out_cnt_nxt;
  logic       w_buf_we;

  coef_in_t   r_buf [0:15];

  logic       w_vld_p0;
  logic       w_last_p0;
  logic [3:0] w_idx_p0;
  coef_in_t   w_x_p0;
  logic [1:0] w_shift_p0;
  coef_out_t  w_q_p0;

  logic       r_vld_p1;
  logic       r_last_p1;
  coef_out_t  r_data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_in_cnt  <= 4'd0;
      r_out_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // A gap in in_valid during LOAD drops the partial block.
  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_out_cnt_nxt = r_out_cnt;
    w_buf_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_buf_we     = 1'b1;
          w_in_cnt_nxt = 4'd1;
          w_state_nxt  = LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          w_buf_we = 1'b1;
          if (r_in_cnt == 4'd15) begin
            w_in_cnt_nxt = 4'd0;
            w_state_nxt  = HOLD;
          end else begin
            w_in_cnt_nxt = r_in_cnt + 4'd1;
          end
        end else begin
          w_in_cnt_nxt = 4'd0;
          w_state_nxt  = IDLE;
        end
      end
      HOLD: begin
        w_out_cnt_nxt = 4'd0;
        w_state_nxt   = OUTPUT;
      end
      OUTPUT: begin
        if (r_out_cnt == 4'd15) begin
          w_out_cnt_nxt = 4'd0;
          w_state_nxt   = IDLE;
        end else begin
          w_out_cnt_nxt = r_out_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        r_buf[i] <= '0;
    end else if (w_buf_we) begin
      r_buf[r_in_cnt] <= bus.in_data;
    end
  end

  // p0: zigzag read and quantize, combinational from state/counter
  assign w_vld_p0  = (r_state == OUTPUT);
  assign w_last_p0 = w_vld_p0 && (r_out_cnt == 4'd15);
  assign w_idx_p0  = ZZ[r_out_cnt];
  assign w_x_p0    = r_buf[w_idx_p0];

`ifdef DCT_ZZ_QUANT_EN
  assign w_shift_p0 = qshift_of(w_idx_p0);
`else
  assign w_shift_p0 = 2'd0;
`endif

  zz_round_shift u_round_shift (
    .i_x (w_x_p0),
    .i_s (w_shift_p0),
    .o_q (w_q_p0)
  );

  // p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1  <= w_vld_p0;
      r_last_p1 <= w_last_p0;
      r_data_p1 <= w_vld_p0 ? w_q_p0 : '0;
    end
  end

  assign bus.out_valid = r_vld_p1;
  assign bus.out_last  = r_last_p1;
  assign bus.out_data  = r_data_p1;

endmodule

// File: tb/tb_dct_zigzag_quant.sv
// Scoreboard bench for dct_zigzag_quant: expected beats are queued at drive time with their due cycle.
module tb_dct_zigzag_quant;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int data;
    int last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   blk[16];
  int   zz_ref[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  dct_zigzag_quant_if bus ();

  dct_zigzag_quant dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_q(input int x, input int idx);
    int s;
    int sum;
    int a;
    int q;
    sum = idx / 4 + idx % 4;
`ifdef DCT_ZZ_QUANT_EN
    if (sum == 0)      s = 0;
    else if (sum <= 2) s = 1;
    else if (sum <= 4) s = 2;
    else               s = 3;
`else
    s = 0;
`endif
    if (s == 0) return x;
    a = (x < 0) ? -x : x;
    q = (2 * a + (1 << s)) / (2 << s);
    return (x < 0) ? -q : q;
  endfunction

  // Drives n samples; queues the first n_exp zigzag beats when n is a full block.
  task automatic drive_block(input int n, input int n_exp, output int c_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 10'(blk[i]);
    end
    c_last = cyc;
    if (n == 16) begin
      for (int j = 0; j < n_exp; j++) begin
        e.data = model_q(blk[zz_ref[j]], zz_ref[j]);
        e.last = (j == 15) ? 1 : 0;
        e.cyc  = c_last + 3 + j;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst || cyc > 3) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_vld", int'(bus.out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("data", int'(bus.out_data), e.data);
          check("last", int'(bus.out_last), e.last);
          check("beat_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_data", int'(bus.out_data), 0);
        check("idle_last", int'(bus.out_last), 0);
      end
    end
  end

  initial begin
    int c;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_vld", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_last", int'(bus.out_last), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = i;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = 7;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = -6;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0]  = 511;
    blk[15] = -512;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = 5;
    drive_block(10, 0, c);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) blk[i] = 3;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 1023)) - 512;
    drive_block(16, 16, c);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = 3 * i - 20;
    drive_block(16, 4, c);
    while (cyc < c + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_vld", int'(bus.out_valid), 0);
    check("rst_mid_last", int'(bus.out_last), 0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) blk[i] = 100 - 13 * i;
    drive_block(16, 16, c);
    repeat (25) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
